// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - RAW forwarding, load-use stall and branch flush control
module hazard_forward_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [REG_AW-1:0] AA_dec,
    input  logic [REG_AW-1:0] BA_dec,
    input  logic [REG_AW-1:0] DA_dec,
    input  logic              MA_dec,
    input  logic              MB_dec,
    input  logic              RW_dec,
    input  logic              LD_dec,
    input  logic              BR_taken,
    output logic              HA,
    output logic              HB,
    output logic              stall,
    output logic              flush,
    output logic              bubble
);

    localparam int CW = $clog2(LOAD_STALL + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_STALL - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0] ex_da_q, ex_da_d;
    logic              ex_rw_q, ex_rw_d;
    logic              ex_ld_q, ex_ld_d;

    logic run;
    logic match_a;
    logic match_b;
    logic luse;

    // Hazard detection and control outputs from the EX record and the DOF operands
    always_comb begin
        run     = (state_q == ST_RUN);
        match_a = ex_rw_q && (ex_da_q == AA_dec) && (AA_dec != '0) && !MA_dec;
        match_b = ex_rw_q && (ex_da_q == BA_dec) && (BA_dec != '0) && !MB_dec;
        luse    = ex_ld_q && (match_a || match_b) && run;
        HA      = match_a && !ex_ld_q && run;
        HB      = match_b && !ex_ld_q && run;
        // A taken branch squashes the dependent instruction, so it overrides any stall
        stall   = (luse || (state_q == ST_STALL)) && !BR_taken;
        flush   = BR_taken && reset_n;
        bubble  = stall || flush;
    end

    // Next EX record and stall sequencing; everything holds while en is low
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_da_d = ex_da_q;
        ex_rw_d = ex_rw_q;
        ex_ld_d = ex_ld_q;
        if (en) begin
            if (bubble) begin
                ex_da_d = '0;
                ex_rw_d = 1'b0;
                ex_ld_d = 1'b0;
            end else begin
                ex_da_d = DA_dec;
                ex_rw_d = RW_dec;
                ex_ld_d = LD_dec;
            end

            if (BR_taken) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else if (state_q == ST_STALL) begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end else if (luse && (LOAD_STALL > 1)) begin
                // With a single stall cycle the EX bubble alone clears the hazard
                state_d = ST_STALL;
                cnt_d   = CNT_INIT;
            end
        end
    end

    // State, counter and EX destination record registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ex_da_q <= '0;
            ex_rw_q <= 1'b0;
            ex_ld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_da_q <= ex_da_d;
            ex_rw_q <= ex_rw_d;
            ex_ld_q <= ex_ld_d;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - scoreboard bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

    localparam int REG_AW     = 5;
    localparam int LOAD_STALL = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              en;
    logic [REG_AW-1:0] AA_dec, BA_dec, DA_dec;
    logic              MA_dec, MB_dec, RW_dec, LD_dec, BR_taken;
    logic              HA, HB, stall, flush, bubble;

    hazard_forward_ctrl #(.REG_AW(REG_AW), .LOAD_STALL(LOAD_STALL)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .AA_dec(AA_dec), .BA_dec(BA_dec), .DA_dec(DA_dec),
        .MA_dec(MA_dec), .MB_dec(MB_dec), .RW_dec(RW_dec), .LD_dec(LD_dec),
        .BR_taken(BR_taken),
        .HA(HA), .HB(HB), .stall(stall), .flush(flush), .bubble(bubble)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [4:0] exp;   // {HA, HB, stall, flush, bubble}
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the instruction sitting in EX and how many more
    // cycles the current load-use stall still has to run after this one.
    bit        m_wr;
    int        m_dest;
    bit        m_load;
    int        m_stall_left;
    bit        c_stall_phase, c_luse, c_bubble;

    function automatic void model_reset();
        m_wr = 0; m_dest = 0; m_load = 0; m_stall_left = 0;
    endfunction

    function automatic logic [4:0] model_outputs();
        bit reads_a, reads_b, dep_a, dep_b, ha, hb, st, fl;
        reads_a = (AA_dec != 0) && !MA_dec;
        reads_b = (BA_dec != 0) && !MB_dec;
        dep_a   = m_wr && reads_a && (int'(AA_dec) == m_dest);
        dep_b   = m_wr && reads_b && (int'(BA_dec) == m_dest);
        c_stall_phase = (m_stall_left > 0);
        c_luse  = m_load && (dep_a || dep_b) && !c_stall_phase;
        ha      = dep_a && !m_load && !c_stall_phase;
        hb      = dep_b && !m_load && !c_stall_phase;
        st      = (c_luse || c_stall_phase) && !BR_taken;
        fl      = BR_taken && reset_n;
        c_bubble = st || fl;
        return {ha, hb, st, fl, c_bubble};
    endfunction

    function automatic void model_edge();
        if (!reset_n || !en) return;
        if (c_bubble) begin
            m_wr = 0; m_load = 0; m_dest = 0;
        end else begin
            m_wr = RW_dec; m_load = LD_dec; m_dest = int'(DA_dec);
        end
        if (BR_taken)           m_stall_left = 0;
        else if (c_stall_phase) m_stall_left = m_stall_left - 1;
        else if (c_luse)        m_stall_left = LOAD_STALL - 1;
    endfunction

    function automatic void push_exp(string tag);
        exp_t e;
        e.tag = tag;
        e.exp = model_outputs();
        exp_q.push_back(e);
    endfunction

    // One pipeline cycle: apply the edge to the model, drive DOF inputs, queue the expectation
    task automatic cyc(input string tag, input bit e, input int aa, input int ba, input int da,
                       input bit ma, input bit mb, input bit rw, input bit ld, input bit br);
        @(posedge clk);
        model_edge();
        #1;
        reset_n  = 1'b1;
        en       = e;
        AA_dec   = REG_AW'(aa);
        BA_dec   = REG_AW'(ba);
        DA_dec   = REG_AW'(da);
        MA_dec   = ma;
        MB_dec   = mb;
        RW_dec   = rw;
        LD_dec   = ld;
        BR_taken = br;
        push_exp(tag);
    endtask

    // Assert reset between clock edges and expect outputs to clear at once
    task automatic mid_reset(input string tag);
        @(posedge clk);
        model_edge();
        #4;
        reset_n = 1'b0;
        model_reset();
        push_exp(tag);
        #3;
    endtask

    // Monitor: compares every queued expectation against the settled DUT outputs
    initial begin
        exp_t       e;
        logic [4:0] act;
        forever begin
            wait (exp_q.size() > 0);
            #1;
            e   = exp_q.pop_front();
            act = {HA, HB, stall, flush, bubble};
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got {HA,HB,stall,flush,bubble}=%b expected %b at %0t",
                         e.tag, act, e.exp, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; en = 1'b0;
        AA_dec = '0; BA_dec = '0; DA_dec = '0;
        MA_dec = 0; MB_dec = 0; RW_dec = 0; LD_dec = 0; BR_taken = 0;
        model_reset();
        #3;
        push_exp("reset_state");
        #10;

        //   tag              en aa ba da ma mb rw ld br
        cyc("add_r3",          1, 0, 0, 3, 0, 0, 1, 0, 0);
        cyc("raw_fwd_a",       1, 3, 7, 0, 0, 0, 0, 0, 0);
        cyc("dest_r0",         1, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc("r0_mask",         1, 0, 0, 5, 0, 0, 1, 0, 0);
        cyc("imm_mask_b",      1, 0, 5, 0, 0, 1, 0, 0, 0);
        cyc("add_r6",          1, 0, 0, 6, 0, 0, 1, 0, 0);
        cyc("fwd_both",        1, 6, 6, 0, 0, 0, 0, 0, 0);

        cyc("ld_r4",           1, 0, 0, 4, 0, 0, 1, 1, 0);
        cyc("luse_stall1",     1, 4, 0, 9, 0, 0, 1, 0, 0);
        cyc("luse_stall2",     1, 4, 0, 9, 0, 0, 1, 0, 0);
        cyc("luse_release",    1, 4, 0, 9, 0, 0, 1, 0, 0);

        cyc("ld_r4_b",         1, 0, 0, 4, 0, 0, 1, 1, 0);
        cyc("br_first_stall",  1, 0, 4, 9, 0, 0, 1, 0, 1);
        cyc("br_after_run",    1, 0, 4, 9, 0, 0, 1, 0, 0);

        cyc("ld_r4_c",         1, 0, 0, 4, 0, 0, 1, 1, 0);
        cyc("frz_luse",        1, 4, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("frz_hold",    0, 4, 0, 0, 0, 0, 0, 0, 0);
        cyc("frz_resume",      1, 4, 0, 0, 0, 0, 0, 0, 0);
        cyc("frz_done",        1, 4, 0, 0, 0, 0, 0, 0, 0);

        cyc("ld_r4_d",         1, 0, 0, 4, 0, 0, 1, 1, 0);
        cyc("br_in_stall_a",   1, 4, 0, 0, 0, 0, 0, 0, 0);
        cyc("br_in_stall_b",   1, 4, 0, 0, 0, 0, 0, 0, 1);
        cyc("br_in_stall_c",   1, 4, 0, 0, 0, 0, 0, 0, 0);

        cyc("ld_r4_e",         1, 0, 0, 4, 0, 0, 1, 1, 0);
        cyc("rst_luse",        1, 4, 0, 0, 0, 0, 0, 0, 0);
        mid_reset("async_reset");
        cyc("post_reset",      1, 4, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            cyc("random",
                ($urandom_range(0, 99) < 85),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 9) == 0));
        end

        #5;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 4-stage RISC pipeline (IF, DOF, EX, WB).
- Drives the HA/HB select lines consumed by the Bus_A/Bus_B operand muxes, which choose forwarded Bus_Dprime instead of register-file data.
- Generates load-use stall and branch flush controls.
- Tracks the destination record of the instruction in EX internally.

Parameters:
- REG_AW, 5, register address width.
- LOAD_STALL, 2, stall cycles inserted on a load-use hazard (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  global pipeline advance; 0 freezes all state.
- AA_dec  in  REG_AW  A source register of instruction in DOF.
- BA_dec  in  REG_AW  B source register of instruction in DOF.
- DA_dec  in  REG_AW  destination register of instruction in DOF.
- MA_dec  in  1  DOF instruction uses PC_1 on Bus_A (no A register read).
- MB_dec  in  1  DOF instruction uses immediate on Bus_B (no B register read).
- RW_dec  in  1  DOF instruction writes a register.
- LD_dec  in  1  DOF instruction is a memory load.
- BR_taken  in  1  branch/jump resolved taken in EX this cycle.
- HA  out  1  forward Bus_Dprime onto Bus_A.
- HB  out  1  forward Bus_Dprime onto Bus_B.
- stall  out  1  hold PC and IF/DOF pipeline registers.
- flush  out  1  squash IF and DOF contents (insert NOP).
- bubble  out  1  load NOP into the EX pipeline register (stall | flush).

Behaviour:
- Reset (async, reset_n=0):
  - ex_DA=0, ex_RW=0, ex_LD=0.
  - State=RUN, cnt=0.
  - All outputs 0.
- EX record update (rising edge, en=1):
  - If bubble=1: ex_RW<=0, ex_LD<=0, ex_DA<=0.
  - Else: ex_DA<=DA_dec, ex_RW<=RW_dec, ex_LD<=LD_dec.
- en=0: record, state and counter hold. Outputs stay combinational from the held state and current inputs.
- Match terms:
  - matchA = ex_RW & (ex_DA==AA_dec) & (AA_dec!=0) & ~MA_dec.
  - matchB = ex_RW & (ex_DA==BA_dec) & (BA_dec!=0) & ~MB_dec.
  - Register 0 is never a hazard.
- Forwarding:
  - HA = matchA & ~ex_LD & (state==RUN).
  - HB = matchB & ~ex_LD & (state==RUN).
  - Both may be 1 simultaneously.
- Load-use detection: luse = ex_LD & (matchA | matchB) & (state==RUN).
- State machine RUN/STALL:
  - RUN:
    - luse=1 and BR_taken=0: stall=1 this cycle. Next state STALL, cnt<=LOAD_STALL-1.
    - If LOAD_STALL=1: stay RUN. The EX bubble clears ex_LD, so luse drops next cycle.
  - STALL:
    - stall=1, HA=HB=0.
    - cnt decrements each en cycle.
    - When cnt==1 at the edge, next state RUN.
    - The register file write-through then supplies the loaded value.
  - stall = luse | (state==STALL).
- Flush:
  - flush = BR_taken.
  - Flush has priority over stall: if BR_taken=1 then stall=0, state<=RUN, cnt<=0. A pending stall is aborted because the dependent instruction is squashed.
- bubble = stall | flush.
- Timing: no output latency. All outputs are combinational functions of registered state and current inputs.
- Counter width: clog2(LOAD_STALL+1). Counter never wraps; it is held at 0 in RUN.
- Reset mid-stall: state returns to RUN, all outputs 0 immediately (asynchronous).
- Same-register dest/source within one instruction (DA_dec==AA_dec) is not a hazard. Only the EX record is compared.

Test Plan:
- RAW forward:
  - EX holds ADD R3 (ex_RW=1, ex_DA=3). DOF AA_dec=3, BA_dec=7, MA/MB=0.
  - Required: HA=1, HB=0, stall=0, bubble=0.
- R0 and immediate masking:
  - ex_DA=0, AA_dec=0: HA=0.
  - ex_DA=5, BA_dec=5, MB_dec=1: HB=0.
- Load-use, LOAD_STALL=2:
  - LD R4 in EX, DOF AA_dec=4.
  - Required: stall=1 for exactly 2 cycles, bubble=1 both cycles, HA=0 throughout.
  - Third cycle: stall=0, ex_RW=0.
- Branch during stall:
  - BR_taken=1 on the first stall cycle.
  - Required: flush=1, stall=0, state RUN next cycle, cnt=0.
- Freeze:
  - en=0 for 3 cycles mid-STALL.
  - Required: cnt and state unchanged, stall stays 1. Resumes counting when en=1.
- Async reset:
  - reset_n low between clock edges during STALL.
  - Required: HA=HB=stall=flush=bubble=0 without waiting for clk. ex_RW=0 after release.
